// File: rtl/seq_detect_pkg.sv
// Shared helpers for the parametrised sequence detector: length-field sizing
// and overlap-mode encodings.
package seq_detect_pkg;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    // Width needed to hold a pattern length from 0 to max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter with synchronous clear and a registered
// saturation flag that rises on the same edge the count reaches all ones.
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // clr outranks inc, so a pulse that arrives with a clear is not counted.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
            sat   <= (count == (CNT_MAX - 1'b1));
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Run-time configurable serial bit-sequence detector with a Mealy match pulse
// and a saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                 MAX_LEN     = 5,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 5'b11101,
    parameter int                 DEF_LEN     = 5,
    parameter logic               DEF_OVERLAP = OVL_ON,
    localparam int                LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din_valid,
    input  logic               din,
    input  logic               count_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    // din is consumed on every edge where din_valid is high and cfg_load is low;
    // there is no ready: the serialiser never sees back-pressure.

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_W = LEN_W'(DEF_LEN);

    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    // The oldest bit would only ever sit outside the window, so it is not kept.
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_p1;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   len_clamped;
    logic               fill_ok;
    logic               window_eq;

    assign cand = {hist, din};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
    end

    assign window_eq   = ((cand ^ pattern) & mask) == '0;
    assign fill_p1     = {1'b0, fill} + (LEN_W + 1)'(1);
    assign fill_ok     = fill_p1 >= {1'b0, len};
    assign match       = din_valid & ~cfg_load & ~reset & (len != '0) & fill_ok & window_eq;
    assign fill_inc    = (fill < len) ? fill + LEN_W'(1) : len;
    assign len_clamped = (cfg_len > MAX_LEN_W) ? MAX_LEN_W : cfg_len;

    always_ff @(posedge clock) begin
        if (reset) begin
            pattern <= DEF_PATTERN;
            len     <= DEF_LEN_W;
            overlap <= DEF_OVERLAP;
            hist    <= '0;
            fill    <= '0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= len_clamped;
            overlap <= cfg_overlap;
            hist    <= '0;
            fill    <= '0;
        end else if (din_valid) begin
            hist <= cand[MAX_LEN-2:0];
            if (!match) begin
                fill <= fill_inc;
            end else if (overlap == OVL_ON) begin
                fill <= len;
            end else begin
                fill <= '0;
            end
        end
    end

    seq_match_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clock(clock),
        .reset(reset),
        .clr  (count_clr),
        .inc  (match),
        .count(match_count),
        .sat  (count_sat)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: a queue-based reference model checked every cycle
// on two instances (8-bit and 2-bit counters), plus literal expectations.
module tb_seq_detect_param;

    localparam int MAX_LEN = 5;

    logic       clock;
    logic       reset;
    logic       cfg_load;
    logic [4:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       cfg_overlap;
    logic       din_valid;
    logic       din;
    logic       count_clr;
    logic       match, match_s;
    logic [7:0] match_count;
    logic [1:0] match_count_s;
    logic       count_sat, count_sat_s;

    seq_detect_param dut (
        .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
        .count_clr(count_clr), .match(match), .match_count(match_count), .count_sat(count_sat)
    );

    seq_detect_param #(.CNT_W(2)) dut_s (
        .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
        .count_clr(count_clr), .match(match_s), .match_count(match_count_s), .count_sat(count_sat_s)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        reset       = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        din_valid   = 1'b0;
        din         = 1'b0;
        count_clr   = 1'b0;
    end

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  running  = 1'b1;
    logic [0:0] exp_q[$];

    // reference model: eligible past bits since the last clear point
    bit         mq[$];
    logic [4:0] m_pat = 5'b11101;
    int         m_len = 5;
    bit         m_ovl = 1'b1;
    int         m_cnt = 0;
    int         m_cnt_s = 0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    endfunction

    function automatic bit model_match();
        if (reset !== 1'b0 || cfg_load || !din_valid || m_len == 0) return 1'b0;
        if (mq.size() + 1 < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            bit b;
            b = (i == 0) ? din : mq[mq.size() - i];
            if (b != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // scoreboard: compare at negedge, then advance the model past the next edge
    always @(negedge clock) begin
        bit em;
        logic [0:0] lit;
        if (running) begin
            em = model_match();
            check("match", match, em);
            check("match_s", match_s, em);
            check("count", match_count, m_cnt);
            check("sat", count_sat, m_cnt == 255);
            check("count_s", match_count_s, m_cnt_s);
            check("sat_s", count_sat_s, m_cnt_s == 3);
            if (exp_q.size() > 0) begin
                lit = exp_q.pop_front();
                check("lit_match", match, lit);
            end
            if (reset) begin
                mq.delete();
                m_pat = 5'b11101;
                m_len = 5;
                m_ovl = 1'b1;
            end else if (cfg_load) begin
                mq.delete();
                m_pat = cfg_pattern;
                m_len = (cfg_len > 3'd5) ? 5 : int'(cfg_len);
                m_ovl = cfg_overlap;
            end else if (din_valid) begin
                if (em && !m_ovl) mq.delete();
                else begin
                    mq.push_back(din);
                    if (mq.size() > MAX_LEN) void'(mq.pop_front());
                end
            end
            if (reset || count_clr) begin
                m_cnt   = 0;
                m_cnt_s = 0;
            end else if (em) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt_s < 3) m_cnt_s++;
            end
        end
    end

    // driver tasks
    task automatic drive(input bit r, ld, clr, v, d, input int exp_m);
        @(posedge clock);
        #1;
        reset = r; cfg_load = ld; count_clr = clr; din_valid = v; din = d;
        if (exp_m >= 0) exp_q.push_back(exp_m[0:0]);
    endtask

    task automatic send(input bit d, input int e);
        drive(1'b0, 1'b0, 1'b0, 1'b1, d, e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic clear(input bit v, d, input int e);
        drive(1'b0, 1'b0, 1'b1, v, d, e);
    endtask

    task automatic load(input logic [4:0] p, input logic [2:0] l, input bit o, v, d, input int e);
        @(posedge clock);
        #1;
        reset = 1'b0; cfg_load = 1'b1; count_clr = 1'b0;
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; din_valid = v; din = d;
        if (e >= 0) exp_q.push_back(e[0:0]);
    endtask

    task automatic send_seq(input logic [15:0] bits, input logic [15:0] exps, input int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i], int'(exps[i]));
    endtask

    task automatic expect_counts(input int c, input int cs, input bit s, input bit ss);
        idle(1);
        @(negedge clock);
        #1;
        check("lit_count", match_count, c);
        check("lit_count_s", match_count_s, cs);
        check("lit_sat", count_sat, s);
        check("lit_sat_s", count_sat_s, ss);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        expect_counts(0, 0, 1'b0, 1'b0);

        // defaults 11101 overlapping
        send_seq(16'b1110111101, 16'b0000100001, 10);
        expect_counts(2, 2, 1'b0, 1'b0);

        // 101 overlapping
        clear(1'b0, 1'b0, 0);
        load(5'b00101, 3'd3, 1'b1, 1'b0, 1'b0, 0);
        send_seq(16'b10101, 16'b00101, 5);
        expect_counts(2, 2, 1'b0, 1'b0);

        // 101 non-overlapping
        clear(1'b0, 1'b0, 0);
        load(5'b00101, 3'd3, 1'b0, 1'b0, 1'b0, 0);
        send_seq(16'b10101, 16'b00100, 5);
        expect_counts(1, 1, 1'b0, 1'b0);

        // gaps in din_valid
        clear(1'b0, 1'b0, 0);
        load(5'b00101, 3'd3, 1'b1, 1'b0, 1'b0, 0);
        send(1'b1, 0);
        send(1'b0, 0);
        idle(3);
        send(1'b1, 1);
        expect_counts(1, 1, 1'b0, 1'b0);

        // len 1, small counter saturation, clear beats a match
        clear(1'b0, 1'b0, 0);
        load(5'b00001, 3'd1, 1'b1, 1'b0, 1'b0, 0);
        send_seq(16'b11111, 16'b11111, 5);
        expect_counts(5, 3, 1'b0, 1'b1);
        clear(1'b1, 1'b1, 1);
        expect_counts(0, 0, 1'b0, 1'b0);

        // reset mid-pattern
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send_seq(16'b1110, 16'b0000, 4);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        send(1'b1, 0);
        send_seq(16'b11101, 16'b00001, 5);

        // cfg_load with a valid bit drops it and restarts the history
        send_seq(16'b1110, 16'b0000, 4);
        load(5'b11101, 3'd5, 1'b1, 1'b1, 1'b1, 0);
        send(1'b1, 0);
        send_seq(16'b1101, 16'b0001, 4);

        // length 0 disables detection
        load(5'b00000, 3'd0, 1'b1, 1'b0, 1'b0, 0);
        repeat (32) send(1'($urandom_range(0, 1)), 0);

        // length above MAX_LEN clamps to 5
        load(5'b11101, 3'd7, 1'b0, 1'b0, 1'b0, 0);
        send_seq(16'b1110111101, 16'b0000100001, 10);

        // 8-bit counter saturation
        clear(1'b0, 1'b0, 0);
        load(5'b00001, 3'd1, 1'b1, 1'b0, 1'b0, 0);
        repeat (260) send(1'b1, 1);
        expect_counts(255, 3, 1'b1, 1'b1);

        // randomized traffic
        clear(1'b0, 1'b0, 0);
        for (int n = 0; n < 800; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) drive(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            else if (r < 7) load(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            else if (r < 10) clear(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            else drive(1'b0, 1'b0, 1'b0, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), -1);
        end

        idle(2);
        @(negedge clock);
        #2;
        running = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
